// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and constants for the program loader.
// The PROG_LOAD_CHECKSUM_EN macro adds the checksum state to the FSM encoding.
package prog_load_ctrl_pkg;

   localparam int unsigned LOAD_LEN_BYTES = 4;
   localparam int unsigned WORD_COUNT_W   = 32;
   localparam logic [1:0]  LAST_BYTE_IDX  = 2'(LOAD_LEN_BYTES - 1);

`ifdef PROG_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN, ST_LOAD, ST_CHK, ST_START, ST_RUN, ST_DONE
   } loader_state_type;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_LEN, ST_LOAD, ST_START, ST_RUN, ST_DONE
   } loader_state_type;
`endif

   function automatic logic len_is_bad(input logic [WORD_COUNT_W-1:0] len,
                                       input int unsigned words);
      return (len == '0) || (len > WORD_COUNT_W'(words));
   endfunction

endpackage

// File: rtl/prog_load_ctrl_word_asm.sv
// Byte-to-word assembler: collects little-endian bytes, exposes the partial
// word and byte index, and pulses word_valid the cycle after the 4th byte.
module uart_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        emit,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [1:0]  byte_idx,
   output logic [23:0] partial
);

   always_ff @(posedge clk) begin
      if (reset) begin
         word_valid <= 1'b0;
         word       <= '0;
         byte_idx   <= '0;
         partial    <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_idx <= '0;
            partial  <= '0;
         end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    partial[7:0]   <= byte_data;
               2'd1:    partial[15:8]  <= byte_data;
               2'd2:    partial[23:16] <= byte_data;
               default: begin
                  // Only payload words reach the output; length words stay internal.
                  if (emit) word <= {byte_data, partial};
                  word_valid <= emit;
                  partial    <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/prog_load_ctrl.sv
// Program load/run sequencer: UART byte stream -> instruction memory, then runs
// the core and measures run length. Optional checksum: PROG_LOAD_CHECKSUM_EN.
module prog_load_ctrl
   import prog_load_ctrl_pkg::*;
#(
   parameter int unsigned IMEM_WORDS     = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   localparam int unsigned AW            = $clog2(IMEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_waddr,
   output logic [31:0]   imem_wdata,
   output logic          core_reset,
   output logic          run_flag,
   input  logic          run_finished,
   output logic          busy,
   output logic          done,
   output logic          load_error,
   output logic [31:0]   run_cycles
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   loader_state_type state_q, state_d;

   logic                    accept, last_byte, waiting, timeout, load_fail;
   logic                    asm_byte_valid;
   logic [1:0]              byte_idx;
   logic [23:0]             partial;
   logic [WORD_COUNT_W-1:0] len_word;
   logic [AW-1:0]           wcnt_q, last_idx_q;
   logic [TW-1:0]           idle_q;
`ifdef PROG_LOAD_CHECKSUM_EN
   logic [7:0]              xor_q;
`endif

   always_comb begin
      rx_ready   = !(state_q inside {ST_START, ST_RUN});
      core_reset = !(state_q inside {ST_START, ST_RUN});
      run_flag   = (state_q == ST_RUN);
      busy       = !(state_q inside {ST_IDLE, ST_DONE});
      done       = (state_q == ST_DONE);
      accept     = rx_valid && rx_ready;
      last_byte  = accept && (byte_idx == LAST_BYTE_IDX);
      len_word   = {rx_data, partial};
`ifdef PROG_LOAD_CHECKSUM_EN
      waiting        = state_q inside {ST_LEN, ST_LOAD, ST_CHK};
      asm_byte_valid = accept && (state_q != ST_CHK);
`else
      waiting        = state_q inside {ST_LEN, ST_LOAD};
      asm_byte_valid = accept;
`endif
      timeout    = waiting && !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));
   end

   uart_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (timeout),
      .byte_valid (asm_byte_valid),
      .byte_data  (rx_data),
      .emit       (state_q == ST_LOAD),
      .word_valid (imem_we),
      .word       (imem_wdata),
      .byte_idx   (byte_idx),
      .partial    (partial)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load_fail = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (accept) state_d = ST_LEN;
         ST_LEN: begin
            if (timeout) begin
               state_d   = ST_IDLE;
               load_fail = 1'b1;
            end else if (last_byte) begin
               if (len_is_bad(len_word, IMEM_WORDS)) begin
                  state_d   = ST_IDLE;
                  load_fail = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (timeout) begin
               state_d   = ST_IDLE;
               load_fail = 1'b1;
            end else if (last_byte && (wcnt_q == last_idx_q)) begin
               // Leave on the final byte so a trailing byte is never dropped;
               // the last write lands in the following cycle.
`ifdef PROG_LOAD_CHECKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_START;
`endif
            end
         end
`ifdef PROG_LOAD_CHECKSUM_EN
         ST_CHK: begin
            if (timeout) begin
               state_d   = ST_IDLE;
               load_fail = 1'b1;
            end else if (accept) begin
               if (rx_data == xor_q) begin
                  state_d = ST_START;
               end else begin
                  state_d   = ST_IDLE;
                  load_fail = 1'b1;
               end
            end
         end
`endif
         ST_START: state_d = ST_RUN;
         ST_RUN:   if (run_finished) state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q     <= '0;
         last_idx_q <= '0;
         idle_q     <= '0;
         imem_waddr <= '0;
         load_error <= 1'b0;
         run_cycles <= '0;
      end else begin
         idle_q <= (waiting && !accept) ? idle_q + 1'b1 : '0;
         if ((state_q inside {ST_IDLE, ST_DONE}) && accept) begin
            load_error <= 1'b0;
            run_cycles <= '0;
         end
         if (load_fail) load_error <= 1'b1;
         if ((state_q == ST_LEN) && last_byte) begin
            wcnt_q     <= '0;
            last_idx_q <= AW'(len_word - 32'd1);
         end
         if ((state_q == ST_LOAD) && last_byte) begin
            imem_waddr <= wcnt_q;
            wcnt_q     <= wcnt_q + 1'b1;
         end
         if ((state_q == ST_RUN) && (run_cycles != '1))
            run_cycles <= run_cycles + 32'd1;
      end
   end

`ifdef PROG_LOAD_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset)                               xor_q <= '0;
      else if ((state_q == ST_LEN) && accept)  xor_q <= '0;
      else if ((state_q == ST_LOAD) && accept) xor_q <= xor_q ^ rx_data;
   end
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl with a frame-level reference model.
// Checksum scenarios are included when PROG_LOAD_CHECKSUM_EN is defined.
module tb_prog_load_ctrl;

   localparam int unsigned IMEM_WORDS = 1024;
   localparam int unsigned TOUT       = 16;
   localparam int unsigned AW         = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          run_finished = 1'b0;
   logic          rx_ready, imem_we, core_reset, run_flag, busy, done, load_error;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata, run_cycles;

   always #5 clk = ~clk;

   prog_load_ctrl #(.IMEM_WORDS(IMEM_WORDS), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .core_reset(core_reset), .run_flag(run_flag),
      .run_finished(run_finished), .busy(busy), .done(done),
      .load_error(load_error), .run_cycles(run_cycles)
   );

   int checks = 0;
   int errors = 0;

   // Observation model: writes seen on the memory port and run_flag history.
   logic [AW+31:0] wr_q[$];
   logic [31:0]    words[$];
   int             cyc = 0, cr_fall = -1, rf_rise = -1, run_hi = 0;
   bit             rf_seen = 0;
   logic           prev_cr = 1'b1, prev_rf = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (imem_we) wr_q.push_back({imem_waddr, imem_wdata});
      if (prev_cr && !core_reset) cr_fall = cyc;
      if (!prev_rf && run_flag) rf_rise = cyc;
      if (run_flag) begin
         run_hi++;
         rf_seen = 1;
      end
      prev_cr = core_reset;
      prev_rf = run_flag;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_obs();
      wr_q.delete();
      run_hi  = 0;
      rf_seen = 0;
      cr_fall = -1;
      rf_rise = -1;
   endtask

   // gap < 0 selects a random 0..2 idle cycles after the byte
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 0;
      int g;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int k = 0; k < 100 && !ok; k++) begin
         ok = rx_ready;
         step();
      end
      rx_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL byte_accept got=0 exp=1 byte=%h", b);
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) step();
   endtask

   task automatic send_len(input logic [31:0] n, input int gap);
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
   endtask

   function automatic logic [7:0] payload_xor();
      logic [7:0] x = '0;
      foreach (words[i]) x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
      return x;
   endfunction

   task automatic send_frame(input int gap);
      logic [31:0] w;
      send_len(words.size(), gap);
      foreach (words[i]) begin
         w = words[i];
         for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
      end
`ifdef PROG_LOAD_CHECKSUM_EN
      send_byte(payload_xor(), gap);
`endif
   endtask

   task automatic random_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   task automatic wait_run(input string name);
      bit ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
         if (run_flag) ok = 1;
         else step();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_run_start got=0 exp=1", name);
      end
   endtask

   // Pulses run_finished in the len-th RUN cycle.
   task automatic finish_run(input int len);
      for (int k = 0; k < 500 && run_hi < len && run_flag; k++) step();
      run_finished = 1'b1;
      step();
      run_finished = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if ({rx_ready, imem_we, core_reset, run_flag, busy, done, load_error} !== 7'b1010000) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=1010000",
                  {rx_ready, imem_we, core_reset, run_flag, busy, done, load_error});
      end
      checks++;
      if ({imem_waddr, imem_wdata, run_cycles} !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h/%h exp=0", imem_waddr, imem_wdata, run_cycles);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_normal_load();
      clear_obs();
      words.delete();
      words.push_back(32'h0000_0093);
      words.push_back(32'h0000_1111);
      send_frame(0);
      wait_run("normal");
      checks++;
      if (wr_q.size() != 2) begin
         errors++;
         $display("FAIL normal_wr_count got=%0d exp=2", wr_q.size());
      end
      for (int i = 0; i < 2; i++) begin
         logic [AW-1:0] a = i[AW-1:0];
         logic [AW+31:0] got = (i < wr_q.size()) ? wr_q[i] : 'x;
         checks++;
         if (got !== {a, words[i]}) begin
            errors++;
            $display("FAIL normal_wr%0d got=%h exp=%h", i, got, {a, words[i]});
         end
      end
      checks++;
      if (rf_rise - cr_fall != 1) begin
         errors++;
         $display("FAIL start_gap got=%0d exp=1", rf_rise - cr_fall);
      end
      checks++;
      if ({busy, core_reset} !== 2'b10) begin
         errors++;
         $display("FAIL run_busy_cr got=%b exp=10", {busy, core_reset});
      end
   endtask

   task automatic test_run_completion();
      finish_run(57);
      checks++;
      if ({run_flag, done, core_reset, busy} !== 4'b0110) begin
         errors++;
         $display("FAIL done_flags got=%b exp=0110", {run_flag, done, core_reset, busy});
      end
      checks++;
      if (run_cycles !== 32'd57 || run_hi != 57) begin
         errors++;
         $display("FAIL run_cycles got=%0d seen=%0d exp=57", run_cycles, run_hi);
      end
      run_finished = 1'b1;
      repeat (3) step();
      run_finished = 1'b0;
      checks++;
      if ({run_flag, done, run_cycles} !== {2'b01, 32'd57}) begin
         errors++;
         $display("FAIL finish_outside_run got=%b/%0d exp=01/57", {run_flag, done}, run_cycles);
      end
   endtask

   task automatic test_random_loads();
      for (int it = 0; it < 4; it++) begin
         int len = int'($urandom_range(3, 40));
         clear_obs();
         random_words(int'($urandom_range(1, 8)));
         send_frame(-1);
         wait_run("random");
         checks++;
         if (wr_q.size() != words.size()) begin
            errors++;
            $display("FAIL random_wr_count got=%0d exp=%0d", wr_q.size(), words.size());
         end
         for (int i = 0; i < words.size(); i++) begin
            logic [AW-1:0] a = i[AW-1:0];
            logic [AW+31:0] got = (i < wr_q.size()) ? wr_q[i] : 'x;
            checks++;
            if (got !== {a, words[i]}) begin
               errors++;
               $display("FAIL random_wr%0d got=%h exp=%h", i, got, {a, words[i]});
            end
         end
         finish_run(len);
         checks++;
         if (run_cycles !== 32'(len) || !done) begin
            errors++;
            $display("FAIL random_run got=%0d done=%b exp=%0d done=1", run_cycles, done, len);
         end
      end
   endtask

   task automatic test_bad_length();
      logic [31:0] bad[2];
      bad[0] = 32'd0;
      bad[1] = IMEM_WORDS + 1;
      for (int t = 0; t < 2; t++) begin
         clear_obs();
         send_len(bad[t], 0);
         repeat (3) step();
         checks++;
         if ({load_error, busy, rf_seen} !== 3'b100 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL bad_len_%0d got=%b wr=%0d exp=100 wr=0",
                     bad[t], {load_error, busy, rf_seen}, wr_q.size());
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      clear_obs();
      random_words(2);
      w = words[0];
      send_len(2, 0);
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
      repeat (TOUT - 1) step();
      checks++;
      if ({load_error, busy} !== 2'b01) begin
         errors++;
         $display("FAIL timeout_early got=%b exp=01", {load_error, busy});
      end
      step();
      checks++;
      if ({load_error, busy} !== 2'b10 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL timeout got=%b wr=%0d exp=10 wr=0", {load_error, busy}, wr_q.size());
      end
      random_words(int'($urandom_range(1, 4)));
      send_byte(8'(words.size()), 0);
      checks++;
      if (load_error !== 1'b0) begin
         errors++;
         $display("FAIL err_clear got=%b exp=0", load_error);
      end
      for (int i = 1; i < 4; i++) send_byte(8'h00, 0);
      foreach (words[i]) begin
         w = words[i];
         for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0);
      end
`ifdef PROG_LOAD_CHECKSUM_EN
      send_byte(payload_xor(), 0);
`endif
      wait_run("after_timeout");
      checks++;
      if (wr_q.size() != words.size() || wr_q[wr_q.size()-1] !== {AW'(words.size()-1), words[words.size()-1]}) begin
         errors++;
         $display("FAIL after_timeout_wr count=%0d exp=%0d", wr_q.size(), words.size());
      end
      finish_run(5);
   endtask

   task automatic test_reload_gapped();
      logic [31:0] w;
      clear_obs();
      words.delete();
      words.push_back(32'hDEAD_BEEF);
      send_byte(8'h01, 2);
      checks++;
      if ({done, busy} !== 2'b01) begin
         errors++;
         $display("FAIL reload_done_clear got=%b exp=01", {done, busy});
      end
      for (int i = 1; i < 4; i++) send_byte(8'h00, 2);
      w = words[0];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], (b == 3) ? 0 : 2);
`ifdef PROG_LOAD_CHECKSUM_EN
      send_byte(payload_xor(), 0);
`endif
      wait_run("reload");
      checks++;
      if (wr_q.size() != 1 || wr_q[0] !== {{AW{1'b0}}, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL reload_wr count=%0d got=%h exp=%h", wr_q.size(),
                  (wr_q.size() > 0) ? wr_q[0] : '0, {{AW{1'b0}}, 32'hDEAD_BEEF});
      end
      finish_run(10);
      checks++;
      if (run_cycles !== 32'd10 || !done) begin
         errors++;
         $display("FAIL reload_run got=%0d exp=10", run_cycles);
      end
      // reset in the middle of a load, then prove the next frame is clean
      random_words(3);
      w = words[0];
      send_len(3, 0);
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0);
      w = words[1];
      send_byte(w[7:0], 0);
      reset = 1'b1;
      step();
      checks++;
      if ({rx_ready, imem_we, core_reset, run_flag, busy, done, load_error} !== 7'b1010000 ||
          {imem_waddr, imem_wdata, run_cycles} !== '0) begin
         errors++;
         $display("FAIL midload_reset got=%b %h/%h/%h exp=1010000 0/0/0",
                  {rx_ready, imem_we, core_reset, run_flag, busy, done, load_error},
                  imem_waddr, imem_wdata, run_cycles);
      end
      reset = 1'b0;
      step();
      clear_obs();
      random_words(2);
      send_frame(0);
      wait_run("post_reset");
      checks++;
      if (wr_q.size() != 2 || wr_q[0] !== {{AW{1'b0}}, words[0]} || wr_q[1] !== {AW'(1), words[1]}) begin
         errors++;
         $display("FAIL post_reset_wr count=%0d exp=2", wr_q.size());
      end
      finish_run(4);
   endtask

`ifdef PROG_LOAD_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] cks[2];
      cks[0] = 8'h04;
      cks[1] = 8'h05;
      for (int t = 0; t < 2; t++) begin
         clear_obs();
         send_len(1, 0);
         for (int b = 4; b >= 1; b--) send_byte(8'(b), 0);
         send_byte(cks[t], 0);
         repeat (4) step();
         checks++;
         if (rf_seen !== (cks[t] == payload_xor_const())) begin
            errors++;
            $display("FAIL checksum_%h run got=%b exp=%b", cks[t], rf_seen, cks[t] == 8'h04);
         end
         checks++;
         if (load_error !== (cks[t] != 8'h04)) begin
            errors++;
            $display("FAIL checksum_%h err got=%b exp=%b", cks[t], load_error, cks[t] != 8'h04);
         end
         if (run_flag) finish_run(run_hi + 1);
      end
   endtask

   function automatic logic [7:0] payload_xor_const();
      logic [31:0] w = 32'h0102_0304;
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction
`endif

   initial begin
      test_reset();
      test_normal_load();
      test_run_completion();
      test_random_loads();
      test_bad_length();
      test_timeout();
      test_reload_gapped();
`ifdef PROG_LOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Sequences program load and run of the core.
- Receives a byte stream from the UART receiver and writes it into instruction memory through the write port.
- Holds the core in reset while loading, then raises run_flag for the fetch stage, and returns to idle when fetch reports the end instruction.
- Also measures run length in cycles.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; AW = $clog2(IMEM_WORDS).
- TIMEOUT_CYCLES, 100000, maximum idle gap between bytes during a load before it is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  byte available from UART receiver
- rx_data  in  8  received byte
- rx_ready  out  1  controller accepts byte; transfer occurs on rx_valid & rx_ready
- imem_we  out  1  instruction memory write strobe
- imem_waddr  out  AW  word address for write
- imem_wdata  out  32  write data
- core_reset  out  1  active-high hold-in-reset for the pipeline
- run_flag  out  1  level to fetch stage; high only in RUN
- run_finished  in  1  from fetch run_finished_next; end instruction reached
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  program completed
- load_error  out  1  sticky error from last load
- run_cycles  out  32  cycles spent in RUN for last run

Behaviour:
- States: IDLE, LEN, LOAD, [CHK], START, RUN, DONE. Reset to IDLE.
- Reset values: rx_ready=1, imem_we=0, imem_waddr=0, imem_wdata=0, core_reset=1, run_flag=0, busy=0, done=0, load_error=0, run_cycles=0.
- rx_ready=1 in IDLE, LEN, LOAD, CHK, DONE; 0 in START, RUN.
- Frame format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian. Byte index 0 goes to bits [7:0].
- IDLE/DONE: an accepted byte is the first length byte. It clears done, load_error and run_cycles, and the state goes to LEN.
- LEN, after the 4th length byte:
  - N==0 or N>IMEM_WORDS: load_error=1, state goes to IDLE.
  - Otherwise state goes to LOAD with word counter 0.
- LOAD: on the 4th byte of a word, the cycle after acceptance has imem_we=1 for exactly one cycle, with imem_waddr=word counter and imem_wdata=assembled word. The counter then increments.
- After write N-1, state goes to START (or CHK if the macro is defined).
- Back-to-back bytes every cycle are supported with no loss.
- Timeout: in LEN/LOAD/CHK, TIMEOUT_CYCLES consecutive cycles with no accepted byte sets load_error=1 and returns to IDLE. Partial words are discarded; memory already written is unchanged.
- core_reset=1 in IDLE, LEN, LOAD, CHK, DONE; 0 in START and RUN.
- START lasts exactly one cycle with run_flag=0, so the core leaves reset before fetch sees run_flag. It then goes to RUN.
- RUN: run_flag=1. run_cycles increments each RUN cycle and saturates at 32'hFFFF_FFFF.
- run_finished=1 goes to DONE the next cycle: run_flag=0, done=1, core_reset=1. run_finished outside RUN is ignored.
- rx bytes arriving in START/RUN are not accepted; the UART backpressures.
- reset mid-load or mid-run returns to the reset values immediately on the clocked edge.

Optional Feature:
- PROG_LOAD_CHECKSUM_EN.
- Defined: after the last word, a CHK state accepts one byte. It must equal the XOR of all N*4 payload bytes.
  - Match: state goes to START.
  - Mismatch: load_error=1, state goes to IDLE; the core never runs.
  - Timeout in CHK applies as for LEN/LOAD.
- Undefined: the CHK state and XOR accumulator are absent, and LOAD goes directly to START.

Decomposition:
- Package common: loader_state_type enum, LOAD_LEN_BYTES=4 constant, word-count width.
- One sub-module: uart_word_assembler. It assembles bytes into little-endian 32-bit words and emits a one-cycle word_valid plus a byte-index count. The FSM, counters and timeout stay in prog_load_ctrl.

Test Plan:
- Normal load: N=2, words 32'h00000093, 32'h00001111, sent back-to-back. Expect imem_we pulses at addr 0 then 1 with those values. Then core_reset falls, run_flag rises one cycle later, busy=1.
- Run completion: in RUN, hold 57 cycles then pulse run_finished. Expect run_flag=0 next cycle, done=1, run_cycles=57, core_reset=1.
- Bad length: N=0 and separately N=IMEM_WORDS+1. Expect load_error=1, state IDLE, no imem_we, run_flag never asserted.
- Timeout: TIMEOUT_CYCLES=16, stop after 2 payload bytes. Expect load_error=1 after 16 idle cycles. A subsequent valid frame clears load_error and runs.
- Reload from DONE with gapped bytes (rx_valid every 3rd cycle), N=1 word 32'hDEADBEEF. Expect done cleared on the first byte, a single write at addr 0, then a run. Reset asserted mid-LOAD returns all outputs to reset values.
- With PROG_LOAD_CHECKSUM_EN: N=1 word 32'h01020304 and checksum 8'h04 gives a run; checksum 8'h05 gives load_error=1 and no run_flag.
